// File: rtl/fire_expand_ofm_writer_if.sv
// Expand-engine sample input and feature-map RAM write port of the fire expand output writer.
// The master side is the producer/observer; the slave side is the writer itself.
interface fire_expand_ofm_writer_if #(
  parameter int DSP_NO = 64,
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int AW     = 19
);
  logic                         wr_layer_en;
  logic                         sample_in;
  logic [0:DSP_NO-1][WIDTH-1:0] ofm_in;
  logic                         wr_en;
  logic [AW-1:0]                wr_addr;
  logic [0:LANES-1][WIDTH-1:0]  wr_data;
  logic                         busy;
  logic                         overflow;
  logic                         done;

  modport master (
    output wr_layer_en, sample_in, ofm_in,
    input  wr_en, wr_addr, wr_data, busy, overflow, done
  );

  modport slave (
    input  wr_layer_en, sample_in, ofm_in,
    output wr_en, wr_addr, wr_data, busy, overflow, done
  );
endinterface

// File: rtl/fire_expand_ofm_writer.sv
// Two-entry vector buffer draining LANES channels/cycle into a channel-interleaved feature map.
// Sample -> first write 2 cycles; no backpressure: a sample arriving with both entries held is dropped (sticky overflow).
module fire_expand_ofm_writer #(
  parameter int WOUT      = 64,
  parameter int DSP_NO    = 64,
  parameter int WIDTH     = 16,
  parameter int LANES     = 4,
  parameter int CH_TOTAL  = 128,
  parameter int CH_OFFSET = 0,
  parameter int AW        = $clog2(WOUT*WOUT*CH_TOTAL)
) (
  input logic                    clk,
  input logic                    rst,
  fire_expand_ofm_writer_if.slave bus
);
  localparam int NBEATS = DSP_NO / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int NPIX   = WOUT * WOUT;
  localparam int PW     = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int VW     = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  typedef enum logic {IDLE, DRAIN} state_t;
  typedef logic [0:DSP_NO-1][WIDTH-1:0] vec_t;
  typedef logic [0:LANES-1][WIDTH-1:0]  lane_t;

  state_t        state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [1:0]    count_q, count_d;
  logic          wp_q, wp_d, rp_q, rp_d;
  logic          ovf_q, ovf_d, done_q, done_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  lane_t         wr_data_q, wr_data_d;
  vec_t          ent_q [2];
  vec_t          ent_d [2];
  vec_t          rd_vec;
  logic [VW-1:0] base;
  logic          offered, freeing, capture;

  always_comb begin
    freeing = (state_q == DRAIN) && (beat_q == BW'(NBEATS-1));
    offered = bus.sample_in && bus.wr_layer_en && !done_q;
    capture = offered && ((count_q != 2'd2) || freeing);

    ent_d   = ent_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    pix_d   = pix_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    state_d = state_q;
    beat_d  = beat_q;
    count_d = count_q + 2'(capture) - 2'(freeing);

    if (capture) begin
      ent_d[wp_q] = bus.ofm_in;
      wp_d        = ~wp_q;
    end
    if (offered && !capture) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if ((count_q != 2'd0) && !done_q) begin
          state_d = DRAIN;
          beat_d  = '0;
        end
      end
      DRAIN: begin
        if (freeing) begin
          rp_d   = ~rp_q;
          beat_d = '0;
          if (pix_q == PW'(NPIX-1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            pix_d   = pix_q + PW'(1);
            state_d = (count_d != 2'd0) ? DRAIN : IDLE;
          end
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A vector captured on the freeing beat lands in the slot being read next; forward it.
    rd_vec = (capture && (wp_q == rp_d)) ? bus.ofm_in : ent_q[rp_d];
    base   = VW'(beat_d) * VW'(LANES);

    wr_en_d   = (state_d == DRAIN);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (state_d == DRAIN) begin
      wr_addr_d = AW'(pix_d) * AW'(CH_TOTAL) + AW'(CH_OFFSET) + AW'(beat_d) * AW'(LANES);
      wr_data_d = rd_vec[base +: LANES];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      pix_q     <= '0;
      count_q   <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      pix_q     <= pix_d;
      count_q   <= count_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = (count_q != 2'd0);
  assign bus.overflow = ovf_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_fire_expand_ofm_writer.sv
// Bench for fire_expand_ofm_writer: expand_1 (offset 0) and expand_3 (offset 64) writers share one stimulus
// and are checked every cycle against a vector-schedule model plus hand-computed literals.
module tb_fire_expand_ofm_writer;
  localparam int WOUT = 64, DSP_NO = 64, WIDTH = 16, LANES = 4, CH_TOTAL = 128, AW = 19;
  localparam int NB = DSP_NO / LANES, NPIX = WOUT * WOUT;

  typedef logic [0:DSP_NO-1][WIDTH-1:0] vec_t;
  typedef logic [0:LANES-1][WIDTH-1:0]  lane_t;
  typedef struct {
    int   capt;
    int   start;
    int   pix;
    vec_t v;
  } job_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic samp, en;
  vec_t vin;

  int checks = 0, errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fire_expand_ofm_writer_if #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES), .AW(AW)) bus_a ();
  fire_expand_ofm_writer_if #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES), .AW(AW)) bus_b ();

  assign bus_a.sample_in = samp;
  assign bus_a.wr_layer_en = en;
  assign bus_a.ofm_in = vin;
  assign bus_b.sample_in = samp;
  assign bus_b.wr_layer_en = en;
  assign bus_b.ofm_in = vin;

  fire_expand_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES),
                           .CH_TOTAL(CH_TOTAL), .CH_OFFSET(0), .AW(AW))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fire_expand_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES),
                           .CH_TOTAL(CH_TOTAL), .CH_OFFSET(64), .AW(AW))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] obs(input logic e, input logic [AW-1:0] a, input lane_t d,
                                       input logic b, input logic o, input logic dn);
    return 128'({e, (e ? a : AW'(0)), (e ? d : lane_t'(0)), b, o, dn});
  endfunction

  // Model: each accepted vector gets a pixel number and a 16-cycle write slot.
  job_t jobs[$];
  int   next_free, n_acc, done_from, ovf_from;

  always @(negedge clk) begin : model
    int    occ, fr, st, beat, e_pix;
    logic  e_en, e_busy, e_done, e_ovf;
    lane_t e_dat;
    job_t  j;
    if (!rst) begin
      jobs.delete();
      next_free = 0; n_acc = 0; done_from = -1; ovf_from = -1;
      check($sformatf("reset_a cycle%0d", cyc),
            128'({bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data, bus_a.busy, bus_a.overflow, bus_a.done}), 128'(0));
      check($sformatf("reset_b cycle%0d", cyc),
            128'({bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data, bus_b.busy, bus_b.overflow, bus_b.done}), 128'(0));
    end else begin
      while (jobs.size() > 0 && jobs[0].start + NB <= cyc) void'(jobs.pop_front());
      e_en = (jobs.size() > 0) && (jobs[0].start <= cyc);
      e_pix = 0; beat = 0; e_dat = '0;
      if (e_en) begin
        beat = cyc - jobs[0].start;
        e_pix = jobs[0].pix;
        for (int k = 0; k < LANES; k++) e_dat[k] = jobs[0].v[beat*LANES + k];
      end
      e_busy = (jobs.size() > 0);
      e_done = (done_from >= 0) && (cyc >= done_from);
      e_ovf  = (ovf_from >= 0) && (cyc >= ovf_from);
      check($sformatf("cycle%0d dut_a", cyc),
            obs(bus_a.wr_en, bus_a.wr_addr, bus_a.wr_data, bus_a.busy, bus_a.overflow, bus_a.done),
            obs(e_en, AW'(e_pix*CH_TOTAL + beat*LANES), e_dat, e_busy, e_ovf, e_done));
      check($sformatf("cycle%0d dut_b", cyc),
            obs(bus_b.wr_en, bus_b.wr_addr, bus_b.wr_data, bus_b.busy, bus_b.overflow, bus_b.done),
            obs(e_en, AW'(e_pix*CH_TOTAL + 64 + beat*LANES), e_dat, e_busy, e_ovf, e_done));
      if (samp && en && !e_done) begin
        occ = jobs.size();
        fr = (jobs.size() > 0 && jobs[0].start + NB - 1 == cyc) ? 1 : 0;
        if (occ - fr < 2) begin
          st = (next_free > cyc) ? next_free : cyc + 2;
          j.capt = cyc; j.start = st; j.pix = n_acc; j.v = vin;
          jobs.push_back(j);
          next_free = st + NB;
          if (n_acc == NPIX - 1) done_from = st + NB;
          n_acc++;
        end else if (ovf_from < 0) begin
          ovf_from = cyc + 1;
        end
      end
    end
  end

  // Observations of dut_a used by the literal end-of-scenario checks.
  int wr_cnt, last_addr, last_wr_cyc, done_cyc;
  always @(negedge clk) begin
    if (!rst) begin
      wr_cnt = 0; last_addr = -1; last_wr_cyc = -1; done_cyc = -1;
    end else begin
      if (bus_a.wr_en) begin
        wr_cnt++; last_addr = int'(bus_a.wr_addr); last_wr_cyc = cyc;
      end
      if (bus_a.done && done_cyc < 0) done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input vec_t v);
    samp = 1'b1; vin = v;
    tick();
    samp = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("async reset outputs",
          128'({bus_a.wr_en, bus_a.busy, bus_a.overflow, bus_a.done, bus_b.wr_en, bus_b.busy}), 128'(0));
    repeat (2) tick();
    rst = 1'b1;
  endtask

  vec_t ramp, pat2, pat3, pat4, vk;
  int   cnt0;

  initial begin
    samp = 1'b0; en = 1'b0; vin = '0;
    for (int i = 0; i < DSP_NO; i++) begin
      ramp[i] = 16'(i);
      pat2[i] = 16'(16'h1000 + 3*i);
      pat3[i] = 16'(16'hA500 ^ i);
      pat4[i] = 16'(16'hFFFF - 5*i);
    end
    tick();
    do_reset();

    // Single vector: writes in T+2..T+17.
    en = 1'b1;
    send(ramp);
    tick(); @(negedge clk);
    check("single beat0 wr_en", 128'(bus_a.wr_en), 128'(1));
    check("single beat0 addr", 128'(bus_a.wr_addr), 128'(0));
    check("single beat0 data", 128'(bus_a.wr_data), 128'({16'd0, 16'd1, 16'd2, 16'd3}));
    repeat (15) tick(); @(negedge clk);
    check("single beat15 addr", 128'(bus_a.wr_addr), 128'(60));
    check("single beat15 data", 128'(bus_a.wr_data), 128'({16'd60, 16'd61, 16'd62, 16'd63}));
    tick(); @(negedge clk);
    check("single after wr_en", 128'(bus_a.wr_en), 128'(0));
    check("single after busy", 128'(bus_a.busy), 128'(0));
    tick();
    do_reset();

    // Back-to-back samples; then two more so reset lands mid pixel 3.
    send(ramp); send(pat2);
    repeat (16) tick(); @(negedge clk);
    check("b2b pix1 first addr a", 128'(bus_a.wr_addr), 128'(128));
    check("b2b pix1 first addr b", 128'(bus_b.wr_addr), 128'(192));
    repeat (15) tick(); @(negedge clk);
    check("b2b pix1 last addr a", 128'(bus_a.wr_addr), 128'(188));
    check("b2b pix1 last addr b", 128'(bus_b.wr_addr), 128'(252));
    tick(); @(negedge clk);
    check("b2b gap wr_en", 128'(bus_a.wr_en), 128'(0));
    check("b2b overflow", 128'(bus_a.overflow), 128'(0));
    tick();
    check("b2b write count", 128'(wr_cnt), 128'(32));
    send(pat3); send(pat4);
    repeat (20) tick();
    check("pix3 draining before reset", 128'(bus_a.wr_en), 128'(1));
    do_reset();

    // Overflow: third back-to-back sample dropped.
    send(ramp); send(pat2); send(pat3);
    @(negedge clk);
    check("overflow set", 128'(bus_a.overflow), 128'(1));
    repeat (40) tick();
    check("overflow write count", 128'(wr_cnt), 128'(32));
    check("overflow sticky", 128'(bus_a.overflow), 128'(1));
    do_reset();

    // Sample on the freeing beat with both entries full is accepted.
    send(ramp); send(pat2);
    repeat (15) tick();
    send(pat3);
    repeat (50) tick();
    check("freeing accept overflow", 128'(bus_a.overflow), 128'(0));
    check("freeing accept write count", 128'(wr_cnt), 128'(48));
    do_reset();

    // Layer disabled: sample ignored.
    en = 1'b0;
    send(ramp);
    tick(); @(negedge clk);
    check("disabled busy", 128'(bus_a.busy), 128'(0));
    tick();

    // Full layer at a 17-cycle sample period.
    en = 1'b1;
    for (int k = 0; k < NPIX; k++) begin
      for (int i = 0; i < DSP_NO; i++) vk[i] = 16'(k*7 + i*13);
      send(vk);
      repeat (16) tick();
    end
    for (int i = 0; i < 200 && !bus_a.done; i++) tick();
    tick();
    check("layer done", 128'(bus_a.done), 128'(1));
    check("layer write count", 128'(wr_cnt), 128'(65536));
    check("layer last addr", 128'(last_addr), 128'(4095*128 + 60));
    check("done one cycle after last write", 128'(done_cyc - last_wr_cyc), 128'(1));
    cnt0 = wr_cnt;
    send(ramp);
    repeat (20) tick();
    check("post-done no write", 128'(wr_cnt), 128'(cnt0));
    check("post-done no overflow", 128'(bus_a.overflow), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
